i2c_slave: RTL



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_monitor.sv | 47 ++++
 rtl/i2c_slave.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target and its bus monitor.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA to clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_level;

  // Idle bus is high on both lines, so reset the chain high to avoid false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_level;
      sda_prev <= sda_level;
    end
  end

  assign scl_level = scl_sync[SYNC_STAGES-1];
  assign sda_level = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_level & ~scl_prev;
  assign scl_fall = ~scl_level & scl_prev;

  // SCL must be high on both samples so an SDA change at an SCL edge is not a condition.
  assign start = scl_level & scl_prev & sda_prev & ~sda_level;
  assign stop  = scl_level & scl_prev & ~sda_prev & sda_level;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, multi-byte write and read, open-drain SDA.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_req,
  output logic              busy
);

  localparam logic [3:0] BITS = 4'(BYTE_W);

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shift;
  logic [BYTE_W-1:0] in_byte;
  logic              rw;
  logic              phase;
  logic              nack;
  logic              sda_low;

  logic sda_level;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_monitor (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .sda_level(sda_level),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign in_byte = {shift[BYTE_W-2:0], sda_level};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= I2C_WRITE;
      phase    <= 1'b0;
      nack     <= 1'b0;
      sda_low  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift   <= in_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BITS - 4'd1) begin
                if (in_byte[BYTE_W-1:1] == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= in_byte[0];
                  phase <= 1'b0;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_low <= 1'b1;
                phase   <= 1'b1;
              end else if (rw == I2C_WRITE) begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                state   <= WRITE;
              end else begin
                // The shift register is loaded one cycle later, while tx_req is high.
                tx_req  <= 1'b1;
                bit_cnt <= 4'd1;
                state   <= READ;
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shift   <= in_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == BITS - 4'd1) begin
                rx_data  <= in_byte;
                rx_valid <= 1'b1;
                phase    <= 1'b0;
                state    <= WRITE_ACK;
              end
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_low <= 1'b1;
                phase   <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                state   <= WRITE;
              end
            end
          end
          READ: begin
            if (tx_req) begin
              shift   <= tx_data;
              sda_low <= ~tx_data[BYTE_W-1];
            end else if (scl_fall) begin
              if (bit_cnt == BITS) begin
                sda_low <= 1'b0;
                phase   <= 1'b0;
                state   <= READ_ACK;
              end else begin
                sda_low <= ~shift[BYTE_W-2];
                shift   <= {shift[BYTE_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              nack  <= sda_level;
              phase <= 1'b1;
            end else if (scl_fall && phase) begin
              if (!nack) begin
                tx_req  <= 1'b1;
                bit_cnt <= 4'd1;
                state   <= READ;
              end else begin
                sda_low <= 1'b0;
                state   <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: sda_low <= 1'b0;
          default: begin
            sda_low <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
